// File: rtl/right_shift_seq_pkg.sv
// Shared constants for the serial right shifter: state codes, default sizes, shift-mode select.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package right_shift_seq_pkg;

   // Default datapath sizing
   localparam int DEF_WIDTH   = 16;
   localparam int DEF_SHAMT_W = 4;

   // Controller states; the encodings are visible to debug tooling, so keep them fixed
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Shift-mode select as driven by instruction decode onto the arith pin
   typedef enum logic {
      SHR_LOGICAL = 1'b0,
      SHR_ARITH   = 1'b1
   } shr_mode_t;

   // Bit shifted in at the top: sign bit for arithmetic shifts, zero for logical shifts
   function automatic logic fill_bit(input logic arith, input logic msb);
      return (shr_mode_t'(arith) == SHR_ARITH) && msb;
   endfunction

endpackage

// File: rtl/right_shift_1b.sv
// Combinational single-bit right step; the counterpart of the 1-bit left shifter.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs continuously.
module right_shift_1b #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] value,
   input  logic             fill,
   output logic [WIDTH-1:0] shifted
);

   // The LSB falls off the end; fill enters at the MSB
   assign shifted = (value >> 1) | {fill, {(WIDTH-1){1'b0}}};

endmodule

// File: rtl/right_shift_seq.sv
// Multi-cycle serial right shifter (logical or arithmetic), one bit per clock.
// Latency: start accepted at edge E0 -> done high in the cycle after edge E0+shamt.
// Backpressure: busy high while shifting; start is dropped (not queued) while busy.
module right_shift_seq
   import right_shift_seq_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int SHAMT_W = DEF_SHAMT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               arith,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   out
);

   localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;
   localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

   state_t             state;
   state_t             state_nxt;
   logic               accept;
   logic [SHAMT_W-1:0] cnt;
   logic               fill;
   logic [WIDTH-1:0]   step_val;

   // Controller state register; reset aborts any shift in progress
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and handshake outputs; a start in DONE chains straight into the next job
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = (shamt == CNT_ZERO) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            busy = 1'b1;
            // Leaving at cnt==1 means the counter never wraps below zero
            if (cnt == CNT_ONE) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = (shamt == CNT_ZERO) ? ST_DONE : ST_SHIFT;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // One-bit step of the result register, filled with the captured fill bit
   right_shift_1b #(
      .WIDTH (WIDTH)
   ) u_step (
      .value   (out),
      .fill    (fill),
      .shifted (step_val)
   );

   // Operand capture on accept, then one step per SHIFT cycle; out is otherwise held
   always_ff @(posedge clk) begin
      if (reset) begin
         out  <= '0;
         cnt  <= '0;
         fill <= 1'b0;
      end else if (accept) begin
         out  <= data_in;
         cnt  <= shamt;
         fill <= fill_bit(arith, data_in[WIDTH-1]);
      end else if (busy) begin
         out  <= step_val;
         cnt  <= cnt - CNT_ONE;
      end
   end

   // Structural sanity: SHIFT always has work left, and busy/done are exclusive
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(busy && done))
            else $error("busy and done asserted together");
         assert (!(state == ST_SHIFT && cnt == CNT_ZERO))
            else $error("shift state entered with zero count");
      end
   end

endmodule
